regfile_mp: RTL and testbench

// - Multi-port register file for the pipelined core; successor to the single-write, two-read regfile.
// - Parametrised in width, depth, read-port count and write-port count, with optional same-cycle write->read bypass.
// - Hard-wired zero register, plus a per-register busy scoreboard that decode uses for RAW hazard detection.
// - Sits between decode (read/issue) and writeback (write ports).
//

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_wr_arb.sv | 28 ++
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared parameters, the address-width helper and common types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Address width for a register file of nregs entries; at least one bit.
  function automatic int unsigned aw(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int unsigned AW_DEF = aw(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port priority resolver for one target address: the highest-index enabled port
// whose address matches wins, giving (hit, data). Used for both the write and bypass paths.
module regfile_wr_arb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NWRITE = 2
) (
  input  logic [AW-1:0]          addr,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  output logic                   hit,
  output logic [XLEN-1:0]        data
);

  // Ascending scan so the last (highest-index) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (we[j] && (wa[j*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wd[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with prioritised write ports, optional same-cycle bypass,
// hard-wired zero register and a per-register busy scoreboard for RAW hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    rs,
  output logic [NREAD*XLEN-1:0]  rv,
  output logic [NREAD-1:0]       rs_busy,
  input  logic [NWRITE-1:0]      we,
  input  logic [NWRITE*AW-1:0]   wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  output logic [NREGS-1:0]       busy
);

  logic [XLEN-1:0]  regs    [NREGS];
  logic [XLEN-1:0]  wr_data [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] wr_en;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] busy_q;

  // Per-register write resolution and scoreboard set terms.
  for (genvar r = 0; r < NREGS; r++) begin : g_wr
    localparam logic [AW-1:0] RA     = AW'(r);
    localparam bit            IS_ZERO = (ZERO_REG != 0) && (r == 0);

    regfile_wr_arb #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_arb (
      .addr (RA),
      .we   (we),
      .wa   (wa),
      .wd   (wd),
      .hit  (wr_hit[r]),
      .data (wr_data[r])
    );

    assign wr_en[r] = wr_hit[r] && !IS_ZERO;
    assign set_v[r] = issue_en && (issue_rd == RA) && !IS_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (wr_en[r]) begin
          regs[r] <= wr_data[r];
        end
      end
    end
  end

  // Set beats clear: a producer issued in the writeback cycle of the previous one keeps busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (set_v[r]) begin
          busy_q[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign busy = busy_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;
    logic            is_zero;
    logic [XLEN-1:0] rd_val;

    assign ra      = rs[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);

    if (BYPASS != 0) begin : g_byp
      regfile_wr_arb #(
        .XLEN   (XLEN),
        .AW     (AW),
        .NWRITE (NWRITE)
      ) u_byp (
        .addr (ra),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .hit  (byp_hit),
        .data (byp_data)
      );
    end else begin : g_nobyp
      assign byp_hit  = 1'b0;
      assign byp_data = '0;
    end

    // Gated by rst_n so bypassed write data cannot leak out while reset is held.
    always_comb begin
      rd_val = regs[ra];
      if (byp_hit) begin
        rd_val = byp_data;
      end
      if (is_zero || !rst_n) begin
        rd_val = '0;
      end
    end

    assign rv[k*XLEN +: XLEN] = rd_val;
    assign rs_busy[k]         = rst_n && busy_q[ra] && !is_zero;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic against
// an array-based reference model; a BYPASS=0 instance shares all inputs.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;
  localparam int NWR   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREAD*AW-1:0]   rs;
  logic [NREAD*XLEN-1:0] rv, rv_nb;
  logic [NREAD-1:0]      rs_busy, rs_busy_nb;
  logic [NWR-1:0]        we;
  logic [NWR*AW-1:0]     wa;
  logic [NWR*XLEN-1:0]   wd;
  logic                  issue_en;
  logic [AW-1:0]         issue_rd;
  logic [NREGS-1:0]      busy, busy_nb;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWR),
               .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rv(rv), .rs_busy(rs_busy),
    .we(we), .wa(wa), .wd(wd), .issue_en(issue_en), .issue_rd(issue_rd), .busy(busy)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWR),
               .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rv(rv_nb), .rs_busy(rs_busy_nb),
    .we(we), .wa(wa), .wd(wd), .issue_en(issue_en), .issue_rd(issue_rd), .busy(busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we = '0; wa = '0; wd = '0; issue_en = 1'b0; issue_rd = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  // Reference: writes in port order so the later port wins; r0 is never written or set busy.
  task automatic model_edge();
    logic [NREGS-1:0] clr;
    if (!rst_n) return;
    clr = '0;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) begin
        clr[wa[j*AW +: AW]] = 1'b1;
        if (wa[j*AW +: AW] != 0) m_regs[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      if (issue_en && issue_rd == r && r != 0) m_busy[r] = 1'b1;
      else if (clr[r]) m_busy[r] = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] exp_rv(int k, bit byp);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = rs[k*AW +: AW];
    if (!rst_n || a == 0) return '0;
    v = m_regs[a];
    if (byp)
      for (int j = 0; j < NWR; j++)
        if (we[j] && wa[j*AW +: AW] == a) v = wd[j*XLEN +: XLEN];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; idle(); rs = '0;
    #2;
    checks++; if (rv !== '0) begin errors++; $display("FAIL reset_rv: got %h expected 0", rv); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy); end
    checks++; if (rs_busy !== '0) begin errors++; $display("FAIL reset_rs_busy: got %b expected 0", rs_busy); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    tick();
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF};
    issue_en = 1'b1; issue_rd = 5'd5;
    tick();
    idle(); rs = {5'd0, 5'd5};
    #1;
    checks++; if (rv[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_r5: got %h expected deadbeef", rv[31:0]); end
    checks++; if (busy[5] !== 1'b1) begin errors++; $display("FAIL pre_reset_busy5: got %b expected 1", busy[5]); end
    #2; rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rv[31:0] !== '0) begin errors++; $display("FAIL async_reset_rv: got %h expected 0", rv[31:0]); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL async_reset_busy: got %h expected 0", busy); end
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h77}; issue_en = 1'b1; issue_rd = 5'd5;
    #1;
    checks++; if (rv[31:0] !== '0) begin errors++; $display("FAIL held_reset_bypass: got %h expected 0", rv[31:0]); end
    @(posedge clk); #1;
    idle();
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (rv[31:0] !== '0) begin errors++; $display("FAIL held_reset_write_ignored: got %h expected 0", rv[31:0]); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL held_reset_issue_ignored: got %h expected 0", busy); end
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h1234};
    tick();
    idle();
    #1;
    checks++; if (rv[31:0] !== 32'h1234) begin errors++; $display("FAIL post_reset_write: got %h expected 1234", rv[31:0]); end
  endtask

  task automatic test_priority();
    idle(); rs = {5'd0, 5'd7};
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h5555_5555, 32'hAAAA_AAAA};
    #1;
    checks++; if (rv[31:0] !== 32'h5555_5555) begin errors++; $display("FAIL prio_bypass: got %h expected 55555555", rv[31:0]); end
    checks++; if (rv_nb[31:0] !== 32'h0) begin errors++; $display("FAIL prio_nobypass_old: got %h expected 0", rv_nb[31:0]); end
    tick();
    idle();
    #1;
    checks++; if (rv[31:0] !== 32'h5555_5555) begin errors++; $display("FAIL prio_stored: got %h expected 55555555", rv[31:0]); end
    checks++; if (rv_nb[31:0] !== 32'h5555_5555) begin errors++; $display("FAIL prio_stored_nb: got %h expected 55555555", rv_nb[31:0]); end
  endtask

  task automatic test_zero();
    idle(); rs = '0;
    we = 2'b01; wa = '0; wd = {32'd0, 32'hFFFF_FFFF}; issue_en = 1'b1; issue_rd = '0;
    #1;
    checks++; if (rv !== '0) begin errors++; $display("FAIL zero_bypass: got %h expected 0", rv); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL zero_busy_now: got %b expected 0", busy[0]); end
    tick();
    idle();
    #1;
    checks++; if (rv !== '0 || rv_nb !== '0) begin errors++; $display("FAIL zero_stored: got %h/%h expected 0", rv, rv_nb); end
    checks++; if (busy[0] !== 1'b0 || rs_busy !== '0) begin errors++; $display("FAIL zero_busy_next: got %b/%b expected 0", busy[0], rs_busy); end
  endtask

  task automatic test_bypass_off();
    idle(); rs = {5'd0, 5'd3};
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h11};
    #1;
    checks++; if (rv_nb[31:0] !== 32'h0) begin errors++; $display("FAIL nobyp_same_cycle: got %h expected 0", rv_nb[31:0]); end
    checks++; if (rv[31:0] !== 32'h11) begin errors++; $display("FAIL byp_same_cycle: got %h expected 11", rv[31:0]); end
    tick();
    idle();
    #1;
    checks++; if (rv_nb[31:0] !== 32'h11) begin errors++; $display("FAIL nobyp_after_edge: got %h expected 11", rv_nb[31:0]); end
  endtask

  task automatic test_scoreboard();
    idle(); rs = {5'd0, 5'd9}; issue_en = 1'b1; issue_rd = 5'd9;
    #1;
    checks++; if (rs_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_before_issue: got %b expected 0", rs_busy[0]); end
    tick();
    idle();
    #1;
    checks++; if (busy[9] !== 1'b1 || rs_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_issued: got %b/%b expected 1/1", busy[9], rs_busy[0]); end
    issue_en = 1'b1; issue_rd = 5'd9; we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'hCAFE};
    #1;
    checks++; if (rs_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_no_clear_bypass: got %b expected 1", rs_busy[0]); end
    tick();
    idle();
    #1;
    checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sb_set_beats_clear: got %b expected 1", busy[9]); end
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'hBEEF};
    tick();
    idle();
    #1;
    checks++; if (busy[9] !== 1'b0 || rs_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_cleared: got %b/%b expected 0/0", busy[9], rs_busy[0]); end
    checks++; if (busy !== m_busy) begin errors++; $display("FAIL sb_vector: got %h expected %h", busy, m_busy); end
  endtask

  task automatic test_parallel();
    idle(); issue_en = 1'b1; issue_rd = 5'd1;
    tick();
    issue_rd = 5'd2;
    tick();
    idle();
    #1;
    checks++; if (busy[2:1] !== 2'b11) begin errors++; $display("FAIL par_busy_set: got %b expected 11", busy[2:1]); end
    we = 2'b11; wa = {5'd2, 5'd1}; wd = {32'h2, 32'h1};
    tick();
    idle(); rs = {5'd2, 5'd1};
    #1;
    checks++; if (rv !== {32'h2, 32'h1}) begin errors++; $display("FAIL par_data: got %h expected 0000000200000001", rv); end
    checks++; if (busy[2:1] !== 2'b00) begin errors++; $display("FAIL par_busy_clear: got %b expected 00", busy[2:1]); end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wa[j*AW +: AW]     = rnd_addr();
        wd[j*XLEN +: XLEN] = $urandom;
      end
      for (int k = 0; k < NREAD; k++) rs[k*AW +: AW] = rnd_addr();
      issue_en = ($urandom_range(0, 2) != 0);
      issue_rd = rnd_addr();
      #1;
      for (int k = 0; k < NREAD; k++) begin
        checks++;
        if (rv[k*XLEN +: XLEN] !== exp_rv(k, 1'b1)) begin
          errors++; $display("FAIL rnd_rv port%0d cyc%0d: got %h expected %h", k, n, rv[k*XLEN +: XLEN], exp_rv(k, 1'b1));
        end
        checks++;
        if (rv_nb[k*XLEN +: XLEN] !== exp_rv(k, 1'b0)) begin
          errors++; $display("FAIL rnd_rv_nb port%0d cyc%0d: got %h expected %h", k, n, rv_nb[k*XLEN +: XLEN], exp_rv(k, 1'b0));
        end
        checks++;
        if (rs_busy[k] !== m_busy[rs[k*AW +: AW]]) begin
          errors++; $display("FAIL rnd_rs_busy port%0d cyc%0d: got %b expected %b", k, n, rs_busy[k], m_busy[rs[k*AW +: AW]]);
        end
      end
      checks++;
      if (busy !== m_busy || busy_nb !== m_busy) begin
        errors++; $display("FAIL rnd_busy cyc%0d: got %h/%h expected %h", n, busy, busy_nb, m_busy);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rs = '0;
    model_reset();
    test_reset();
    test_priority();
    test_zero();
    test_bypass_off();
    test_scoreboard();
    test_parallel();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
